// File: rtl/spike_arb_pkg.sv
// Shared types and constants for the spike handshake arbiter.
package spike_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_UP  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Width of a requester index; clamped to 1 so a single requester still has a port.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
module sync_ff
    import spike_arb_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spike_handshake_arbiter.sv
// Round-robin arbiter sharing one downstream 4-phase spike channel among N_REQ async requesters.
// Optional downstream-ack timeout with sticky err_o is enabled by defining ARB_TIMEOUT_EN.
module spike_handshake_arbiter
    import spike_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_i,
    output logic [N_REQ-1:0]              ack_o,
    output logic                          out_req_o,
    input  logic                          out_ack_i,
    output logic [id_width(N_REQ)-1:0]    out_id_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned ID_W = id_width(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spike_handshake_arbiter: parameter out of range");
    end

    logic [N_REQ-1:0] sreq;
    logic             sack;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
            .clk (clk),
            .rst (rst),
            .d_i (req_i[g]),
            .q_o (sreq[g])
        );
    end

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d_i (out_ack_i),
        .q_o (sack)
    );

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             out_req_q, out_req_d;
    logic             busy_q, busy_d;

    logic             timeout_hit;
    logic             supp_active;

    // Round-robin search: first synchronized request at or above ptr, wrapping.
    logic [ID_W-1:0]  sel;
    logic             any_req;
    int unsigned      j;

    always_comb begin
        sel     = ptr_q;
        any_req = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any_req && sreq[ID_W'(j)]) begin
                any_req = 1'b1;
                sel     = ID_W'(j);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
    logic             supp_q;

    // Counter restarts on every entry to REQ; timeout fires on the TIMEOUT_CYCLES-th REQ cycle.
    always_comb begin
        cnt_d = '0;
        if (state_q == REQ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == REQ) && !sack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign supp_active = supp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            supp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
                err_q  <= 1'b1;
                supp_q <= 1'b1;
            end else if (state_q == RELEASE) begin
                supp_q <= 1'b0;
            end
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign supp_active = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            out_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            out_req_q <= out_req_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        out_req_d = out_req_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d      = sel;
                    out_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (sack) begin
                    out_req_d   = 1'b0;
                    ack_d[id_q] = 1'b1;
                    state_d     = ACK_UP;
                end else if (timeout_hit) begin
                    out_req_d = 1'b0;
                    state_d   = ACK_UP;
                end
            end
            // After a timeout only the downstream side must return to zero.
            ACK_UP: begin
                if (!sack && (supp_active || !sreq[id_q])) begin
                    ack_d[id_q] = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign ack_o     = ack_q;
    assign out_req_o = out_req_q;
    assign out_id_o  = id_q;
    assign busy_o    = busy_q;

endmodule

// File: doc/spike_handshake_arbiter.md
Name: spike_handshake_arbiter

Overview:
- Synchronous arbiter that shares one downstream 4-phase spike channel between N_REQ asynchronous neuron controllers.
- Each requester drives a 4-phase req/ack pair. The arbiter synchronizes the pair, grants one requester round-robin, relays the handshake downstream with a bundled requester ID, then completes the upstream handshake.
- Sits between the neuron controller outputs and the spike router/output port.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- SYNC_STAGES, 2, synchronizer depth on every async input (>=2)
- TIMEOUT_CYCLES, 255, downstream ack timeout in clk cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_i  in  N_REQ  per-requester 4-phase request (async)
- ack_o  out  N_REQ  per-requester 4-phase acknowledge, registered
- out_req_o  out  1  downstream request, registered
- out_ack_i  in  1  downstream acknowledge (async)
- out_id_o  out  $clog2(N_REQ)  granted requester index, bundled with out_req_o
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky timeout flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset: async, active-high. Decided: one clock (clk); reset rst is asynchronous and active-high.
  - While rst=1: ack_o=0, out_req_o=0, out_id_o=0, busy_o=0, err_o=0, all synchronizer flops=0, round-robin pointer=0, state=IDLE.
  - Reset mid-handshake abandons the transfer immediately; no completion is attempted.
- Synchronizers: every req_i bit and out_ack_i pass through SYNC_STAGES flops. The FSM sees only synchronized values (sreq, sack).
- States: IDLE -> REQ -> ACK_UP -> RELEASE -> IDLE.
  - IDLE: if any sreq bit is set, select the first set bit searching from ptr upward with wrap. Register out_id_o=sel and out_req_o=1, then go to REQ. If no sreq bit is set, stay.
  - REQ: hold out_req_o=1. When sack=1: set out_req_o=0 and ack_o[id]=1, then go to ACK_UP.
  - ACK_UP: wait until sreq[id]=0 and sack=0. Then set ack_o[id]=0 and go to RELEASE.
  - RELEASE: one cycle. Set ptr=id+1, wrapping to 0 after N_REQ-1. Go to IDLE.
- Latency:
  - out_req_o rises exactly SYNC_STAGES+1 clk edges after req_i rises from idle.
  - ack_o[id] rises SYNC_STAGES+1 edges after out_ack_i rises.
- Hold rule: out_id_o is stable from the rise of out_req_o until RELEASE.
- One-hot rule: at most one ack_o bit is high at any time.
- Simultaneous requests: strict round-robin. Worst-case wait for any requester is N_REQ-1 complete transfers.
- Late requests: a request arriving during a transfer waits. It is never dropped.
- Request withdrawn before grant: if req_i[k] falls before IDLE samples it, no grant is issued.
- Request withdrawn after grant: the transfer completes normally.
- Tie at ptr: if the requester at ptr is the only one requesting, it is granted even when it was the last one served.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ.
  - When the count reaches TIMEOUT_CYCLES with sack still 0: err_o=1 (sticky until rst), out_req_o=0, no ack_o is raised, state goes to ACK_UP with upstream completion suppressed.
  - In ACK_UP, the FSM waits for sack=0, then proceeds through RELEASE as normal. The requester's req stays pending and is re-arbitrated.
- Undefined: no counter logic; err_o is constant 0.

Decomposition:
- Package spike_arb_pkg:
  - state enum arb_state_t {IDLE, REQ, ACK_UP, RELEASE}
  - localparam-style function id_width(n) = $clog2(n)
  - default SYNC_STAGES constant
- Sub-module sync_ff:
  - Parameterized-depth single-bit synchronizer with async active-high reset to 0.
  - Instantiated N_REQ+1 times.

Test Plan:
- Single requester: req_i=4'b0100 -> out_req_o high after 3 edges with out_id_o=2. Drive out_ack_i=1 -> ack_o=4'b0100 after 3 edges. Drop req_i[2] and out_ack_i -> ack_o=0, then busy_o=0 one cycle after RELEASE.
- All four requesting simultaneously from reset, downstream responder acking 5 cycles after each req: grant order is IDs 0,1,2,3,0.
- Requester 1 raises req while requester 3 is mid-transfer: ID 1 is granted immediately after RELEASE, and out_id_o never changes while out_req_o=1.
- Assert rst while in ACK_UP with ack_o=4'b0001: all outputs are 0 in the same cycle. After release, a request on ID 3 is granted first search from ptr=0.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, out_ack_i held 0: out_req_o falls 16 cycles after rising, err_o=1 and stays 1, and ack_o is never asserted.
- Glitch check: pulse req_i[0] for 1 clk with SYNC_STAGES=2, sampled-low alignment: no grant, and busy_o stays 0.
